// File: rtl/arbitro_direcciones.sv
// Burst address arbiter: grants one of N_CH requesters and walks its burst one address per step.
// Address valid one cycle after the granting edge; step is the only backpressure and holds all outputs when low.
module arbitro_direcciones #(
  parameter int          N_CH      = 3,
  parameter int          AW        = 4,
  parameter int          LW        = 4,
  parameter int          MODE      = 0,
  parameter logic [AW-1:0] IDLE_ADDR = '0,
  localparam int         GW        = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*AW-1:0]   base_addr,
  input  logic [N_CH*LW-1:0]   burst_len,
  input  logic                 step,
  output logic [AW-1:0]        Address_WR,
  output logic                 addr_valid,
  output logic [N_CH-1:0]      grant,
  output logic [GW-1:0]        grant_idx,
  output logic                 busy,
  output logic [N_CH-1:0]      done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [GW-1:0]   gidx_q, gidx_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            win_vld;
  logic [GW-1:0]   win_idx;
  logic [AW-1:0]   win_base;
  logic [LW-1:0]   win_len;
  int              best_rank;
  int              rank;
  logic [N_CH-1:0] gidx_dec;

  // Lowest rank wins: fixed priority ranks by descending index,
  // round-robin ranks by distance above the last granted channel.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    win_base  = base_addr[AW-1:0];
    win_len   = burst_len[LW-1:0];
    best_rank = N_CH;
    rank      = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (MODE == 0) begin
        rank = N_CH - 1 - i;
      end else begin
        rank = (i + 2 * N_CH - 1 - int'(rr_ptr_q)) % N_CH;
      end
      if (req[i] && (rank < best_rank)) begin
        best_rank = rank;
        win_vld   = 1'b1;
        win_idx   = GW'(i);
        win_base  = base_addr[i*AW +: AW];
        win_len   = burst_len[i*LW +: LW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_RUN;
          gidx_d  = win_idx;
          addr_d  = win_base;
          rem_d   = (win_len == '0) ? LW'(1) : win_len;
          if (MODE != 0) begin
            rr_ptr_d = win_idx;
          end
        end
      end
      ST_RUN: begin
        if (step) begin
          if (rem_q == LW'(1)) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - LW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= IDLE_ADDR;
      rem_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= GW'(N_CH - 1);
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    gidx_dec = '0;
    for (int i = 0; i < N_CH; i++) begin
      gidx_dec[i] = (gidx_q == GW'(i));
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them immediately.
  assign addr_valid = (state_q == ST_RUN);
  assign Address_WR = addr_valid ? addr_q : IDLE_ADDR;
  assign grant      = addr_valid ? gidx_dec : '0;
  assign grant_idx  = addr_valid ? gidx_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE) ? gidx_dec : '0;

endmodule

// File: tb/tb_arbitro_direcciones.sv
// Bench for arbitro_direcciones: fixed-priority and round-robin instances against a transaction-level model.
module tb_arbitro_direcciones;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int LW = 4;
  localparam int BW = N * AW;
  localparam int LB = N * LW;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] base_addr;
  logic [LB-1:0] burst_len;
  logic [N-1:0]  req_a, req_b;
  logic          step_a, step_b;

  logic [AW-1:0] addr_a, addr_b;
  logic          vld_a, vld_b, busy_a, busy_b;
  logic [N-1:0]  grant_a, grant_b, done_a, done_b;
  logic [1:0]    gidx_a, gidx_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  arbitro_direcciones #(.N_CH(N), .AW(AW), .LW(LW), .MODE(0)) u_fp (
    .clk(clk), .reset(reset), .req(req_a), .base_addr(base_addr), .burst_len(burst_len),
    .step(step_a), .Address_WR(addr_a), .addr_valid(vld_a), .grant(grant_a),
    .grant_idx(gidx_a), .busy(busy_a), .done(done_a)
  );

  arbitro_direcciones #(.N_CH(N), .AW(AW), .LW(LW), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .req(req_b), .base_addr(base_addr), .burst_len(burst_len),
    .step(step_b), .Address_WR(addr_b), .addr_valid(vld_b), .grant(grant_b),
    .grant_idx(gidx_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 50) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = fixed priority instance, 1 = round-robin instance.
  bit m_act[2];
  bit m_done[2];
  int m_ch[2];
  int m_addr[2];
  int m_left[2];
  int m_rr[2];

  task automatic model_step(input int m, input logic [N-1:0] r, input logic s);
    int w, c, len;
    w = -1;
    if (m_done[m]) begin
      m_done[m] = 1'b0;
    end else if (m_act[m]) begin
      if (s) begin
        if (m_left[m] == 1) begin
          m_act[m]  = 1'b0;
          m_done[m] = 1'b1;
        end else begin
          m_addr[m] = (m_addr[m] + 1) % (1 << AW);
          m_left[m] = m_left[m] - 1;
        end
      end
    end else begin
      if (m == 0) begin
        for (int i = 0; i < N; i++) if (((r >> i) & 1) != 0) w = i;
      end else begin
        for (int k = N; k >= 1; k--) begin
          c = (m_rr[m] + k) % N;
          if (((r >> c) & 1) != 0) w = c;
        end
      end
      if (w >= 0) begin
        m_act[m]  = 1'b1;
        m_ch[m]   = w;
        m_addr[m] = int'(base_addr >> (w * AW)) % (1 << AW);
        len       = int'(burst_len >> (w * LW)) % (1 << LW);
        m_left[m] = (len == 0) ? 1 : len;
        m_rr[m]   = w;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_act[m] = 1'b0; m_done[m] = 1'b0; m_ch[m] = 0;
        m_addr[m] = 0; m_left[m] = 0; m_rr[m] = N - 1;
      end
    end else begin
      model_step(0, req_a, step_a);
      model_step(1, req_b, step_b);
    end
  end

  task automatic cmp(input string p, input int m, input logic [AW-1:0] a, input logic v,
                     input logic [N-1:0] g, input logic [1:0] gi, input logic b, input logic [N-1:0] d);
    chk({p, "_addr"},  a,  m_act[m] ? m_addr[m] : 0);
    chk({p, "_valid"}, v,  m_act[m]);
    chk({p, "_grant"}, g,  m_act[m] ? (1 << m_ch[m]) : 0);
    chk({p, "_gidx"},  gi, m_act[m] ? m_ch[m] : 0);
    chk({p, "_busy"},  b,  m_act[m] | m_done[m]);
    chk({p, "_done"},  d,  m_done[m] ? (1 << m_ch[m]) : 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("fp", 0, addr_a, vld_a, grant_a, gidx_a, busy_a, done_a);
      cmp("rr", 1, addr_b, vld_b, grant_b, gidx_b, busy_b, done_b);
    end
  end

  int order[$];
  int cyc, nvld, ndone, cur;
  int wrap_seq[3] = '{14, 15, 0};
  int fp_exp[3]   = '{2, 1, 0};
  int rr_exp[4]   = '{0, 1, 2, 0};
  int stall_seq[3] = '{6, 7, 8};

  initial begin
    reset = 1'b0;
    req_a = '0; req_b = '0; step_a = 1'b0; step_b = 1'b0;
    base_addr = '0; burst_len = '0;

    // Reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      req_a = N'($urandom); req_b = N'($urandom);
      step_a = 1'($urandom); step_b = 1'($urandom);
      base_addr = BW'($urandom); burst_len = LB'($urandom);
    end
    @(negedge clk);
    chk("rst_addr", addr_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_grant", grant_b, 0);
    chk("rst_busy", busy_b, 0);
    req_a = '0; req_b = '0; step_a = 1'b0; step_b = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy_fp", busy_a, 0);
    chk("idle_busy_rr", busy_b, 0);

    // Wrapping burst on ch0: E, F, 0 then done
    base_addr = {4'h0, 4'h0, 4'hE};
    burst_len = {4'd0, 4'd0, 4'd3};
    req_a = 3'b001; step_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wrap_addr", addr_a, wrap_seq[i]);
      chk("wrap_valid", vld_a, 1);
    end
    @(negedge clk);
    chk("wrap_done", done_a, 3'b001);
    chk("wrap_done_valid", vld_a, 0);
    req_a = '0;
    @(negedge clk);
    chk("wrap_idle_done", done_a, 0);
    chk("wrap_idle_busy", busy_a, 0);
    step_a = 1'b0;

    // Fixed-priority contention
    base_addr = {4'h3, 4'h2, 4'h1};
    burst_len = {4'd1, 4'd1, 4'd1};
    req_a = 3'b111; step_a = 1'b1;
    order.delete(); cyc = 0; cur = -1;
    while (req_a != 0 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (vld_a) cur = gidx_a;
      if (done_a != 0) begin
        order.push_back(cur);
        req_a = req_a & ~done_a;
      end
    end
    if (cyc >= 40) chk("fp_timeout", 1, 0);
    for (int i = 0; i < 3; i++) chk("fp_order", (i < order.size()) ? order[i] : 99, fp_exp[i]);
    req_a = '0; step_a = 1'b0;

    // Round-robin with requests held
    burst_len = {4'd2, 4'd2, 4'd2};
    req_b = 3'b111; step_b = 1'b1;
    order.delete(); cyc = 0; nvld = 0; ndone = 0; cur = -1;
    while (ndone < 4 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (vld_b) begin nvld++; cur = gidx_b; end
      if (done_b != 0) begin order.push_back(cur); ndone++; end
    end
    req_b = '0; step_b = 1'b0;
    if (cyc >= 80) chk("rr_timeout", 1, 0);
    for (int i = 0; i < 4; i++) chk("rr_order", (i < order.size()) ? order[i] : 99, rr_exp[i]);
    chk("rr_addr_count", nvld, 8);
    @(negedge clk);

    // Zero length burst yields exactly one address
    base_addr = {4'h0, 4'h0, 4'h7};
    burst_len = {4'd0, 4'd0, 4'd0};
    req_a = 3'b001; step_a = 1'b1;
    cyc = 0; nvld = 0; ndone = 0;
    while (ndone == 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (vld_a) begin nvld++; chk("len0_addr", addr_a, 7); end
      if (done_a != 0) begin ndone++; req_a = '0; end
    end
    chk("len0_count", nvld, 1);
    @(negedge clk);

    // Stall mid-burst, inputs change after grant
    base_addr = {4'h0, 4'h5, 4'h0};
    burst_len = {4'd0, 4'd4, 4'd0};
    req_a = 3'b010; step_a = 1'b0;
    @(negedge clk);
    chk("stall_first", addr_a, 5);
    base_addr = BW'($urandom); burst_len = LB'($urandom); req_a = '0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", addr_a, 5);
      chk("stall_nodone", done_a, 0);
    end
    step_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", addr_a, stall_seq[i]);
    end
    @(negedge clk);
    chk("stall_done", done_a, 3'b010);
    @(negedge clk);
    step_a = 1'b0;

    // Asynchronous reset after the second address of a 4-address burst
    base_addr = {4'h0, 4'h0, 4'h8};
    burst_len = {4'd0, 4'd0, 4'd4};
    req_a = 3'b001; step_a = 1'b1;
    @(negedge clk);
    chk("mid_addr0", addr_a, 8);
    @(negedge clk);
    chk("mid_addr1", addr_a, 9);
    #1 reset = 1'b0;
    #1;
    chk("async_addr", addr_a, 0);
    chk("async_valid", vld_a, 0);
    chk("async_busy", busy_a, 0);
    chk("async_grant", grant_a, 0);
    req_a = '0; step_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_a != 0 || busy_a) ndone++;
    end
    chk("post_reset_quiet", ndone, 0);

    // Random traffic on both instances
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #2;
      reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      req_a = N'($urandom); req_b = N'($urandom);
      step_a = ($urandom_range(0, 9) < 7); step_b = ($urandom_range(0, 9) < 7);
      base_addr = BW'($urandom); burst_len = LB'($urandom);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
